iomem_host_bridge: RTL and testbench
====================================

Name: iomem_host_bridge

Overview:
- Byte-stream-to-iomem bus initiator: decodes read/write command frames arriving on a byte stream (fed by a UART receiver) and issues single iomem transactions.
- Sits alongside the soc on the same iomem responder bus, so a host PC can read the frequency-counter, epoch and gpio registers, and write gpio, without firmware involvement.
- Returns status and read data as a response byte stream on a second byte interface.

Parameters:
- TIMEOUT_CYCLES, 1024: clk cycles to wait for iomem_ready before aborting the transaction; legal range 2..65535.
- TO_BITS, 16: width of the timeout counter; must satisfy 2^TO_BITS > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- rx_valid  in  1  command byte valid.
- rx_data  in  8  command byte.
- rx_ready  out  1  bridge accepts rx_data when rx_valid && rx_ready.
- tx_valid  out  1  response byte valid.
- tx_data  out  8  response byte.
- tx_ready  in  1  sink accepts the response byte when tx_valid && tx_ready.
- iomem_valid  out  1  bus request.
- iomem_ready  in  1  single-cycle completion pulse from the responder.
- iomem_wstrb  out  4  byte strobes; 4'hF for a write, 0 for a read.
- iomem_addr  out  32  bus address.
- iomem_wdata  out  32  write data.
- iomem_rdata  in  32  read data, valid in the iomem_ready cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs are registered and reset to 0; state=IDLE. rx_ready rises in the first clk edge after resetn deasserts.
- Frames: opcode byte, then 4 address bytes MSB first; a write frame adds 4 data bytes MSB first.
  - Opcode 0x52 ('R') is a read.
  - Opcode 0x57 ('W') is a write.
- Responses:
  - Read OK: 0x00 followed by 4 rdata bytes, MSB first.
  - Write OK: 0x00.
  - Timeout: 0xEE only.
  - Bad opcode: 0x3F only.
- States: IDLE -> ADDR -> [DATA] -> BUS -> RESP -> IDLE.
- IDLE, rx_ready=1, on an accepted byte:
  - 0x52 or 0x57: latch the opcode, go to ADDR.
  - Any other value: load response 0x3F, go to RESP.
- ADDR, rx_ready=1: shift each accepted byte into the address register (addr <= {addr[23:0], byte}). After the 4th byte:
  - Write: go to DATA.
  - Read: go to BUS.
- DATA, rx_ready=1: shift 4 bytes into wdata in the same way, then go to BUS.
- BUS, rx_ready=0:
  - Assert iomem_valid starting the cycle after entry.
  - Drive iomem_wstrb = 4'hF for a write and 0 for a read; addr, wdata and wstrb stay stable while iomem_valid=1.
  - The timeout counter clears on entry and increments every cycle iomem_valid=1.
  - On the iomem_ready cycle: capture iomem_rdata. iomem_valid and iomem_wstrb go to 0 at the next edge (never held into a second cycle after ready). Go to RESP with status 0x00.
  - If the counter reaches TIMEOUT_CYCLES-1 without ready: drop iomem_valid, go to RESP with status 0xEE, discard rdata.
  - If iomem_ready and the timeout occur in the same cycle, ready wins.
  - iomem_ready while iomem_valid=0 is ignored.
- RESP, rx_ready=0:
  - Present bytes in order, each held on tx_valid/tx_data until tx_ready is sampled high.
  - tx_valid may stay high back-to-back between bytes.
  - After the last byte: tx_valid=0, go to IDLE.
  - Byte count is 1 or 5, tracked with a 3-bit index; no wrap beyond 5.
- Bytes arriving while rx_ready=0 are not consumed; the source stalls.
- No inter-byte timeout: a partial frame waits indefinitely.
- resetn asserted mid-frame or mid-transaction:
  - Immediately drops iomem_valid, tx_valid and rx_ready.
  - Returns to IDLE; the partial frame is lost.
- A single transaction is in flight at most; the responder never sees a back-to-back request without at least one cycle of iomem_valid=0.

Test Plan:
- Read 52 03 00 00 04, responder returns ready after 3 cycles with rdata=0x12345678 -> tx bytes 00 12 34 56 78; iomem_addr=0x03000004, wstrb=0 throughout; valid high exactly 3 cycles then low.
- Write 57 03 00 00 00 00 00 00 0A -> one bus cycle with addr=0x03000000, wdata=0x0000000A, wstrb=4'hF; tx byte 00.
- Read to an address with no responder (ready never asserted), TIMEOUT_CYCLES=16 -> iomem_valid high 16 cycles then low; tx byte EE; next frame is processed normally.
- Opcode 0xA5 -> tx byte 3F; bridge returns to IDLE. A following valid read completes correctly.
- tx_ready held low 10 cycles per byte during a read response -> tx_data stable while tx_valid=1 and unaccepted; rx_ready stays 0 until the 5th byte is accepted.
- resetn pulsed low after 3 address bytes, and separately during BUS -> all outputs 0 asynchronously; a full read frame afterwards returns correct data.

Source files
------------

// File: rtl/iomem_host_bridge.sv
// Host-side iomem initiator: parses 'R'/'W' command frames from a byte stream,
// runs one iomem transaction per frame and streams back status and read data.
module iomem_host_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_BITS        = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam logic [7:0] ST_BADOP   = 8'h3F;
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t             state;
    logic               is_write;
    logic [1:0]         byte_cnt;
    logic [TO_BITS-1:0] to_cnt;
    logic [31:0]        rdata_q;
    logic [2:0]         resp_idx;
    logic [2:0]         resp_last;
    logic               rx_fire;
    logic               tx_fire;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;

    // Response byte idx (1..4) carries read data MSB first; byte 0 is the status.
    function automatic logic [7:0] rdata_byte(input logic [31:0] w, input logic [2:0] idx);
        case (idx)
            3'd1:    return w[31:24];
            3'd2:    return w[23:16];
            3'd3:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'h0;
            iomem_addr  <= 32'h0;
            iomem_wdata <= 32'h0;
            busy        <= 1'b0;
            is_write    <= 1'b0;
            byte_cnt    <= 2'd0;
            to_cnt      <= '0;
            rdata_q     <= 32'h0;
            resp_idx    <= 3'd0;
            resp_last   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        busy     <= 1'b1;
                        byte_cnt <= 2'd0;
                        if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                            is_write <= (rx_data == OP_WRITE);
                            state    <= S_ADDR;
                        end else begin
                            rx_ready  <= 1'b0;
                            tx_valid  <= 1'b1;
                            tx_data   <= ST_BADOP;
                            resp_idx  <= 3'd0;
                            resp_last <= 3'd0;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        iomem_addr <= {iomem_addr[23:0], rx_data};
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= S_DATA;
                            end else begin
                                rx_ready <= 1'b0;
                                to_cnt   <= '0;
                                state    <= S_BUS;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        iomem_wdata <= {iomem_wdata[23:0], rx_data};
                        byte_cnt    <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            rx_ready <= 1'b0;
                            to_cnt   <= '0;
                            state    <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Entry cycle only issues the request; ready is not looked at until valid is up.
                    if (!iomem_valid) begin
                        iomem_valid <= 1'b1;
                        iomem_wstrb <= is_write ? 4'hF : 4'h0;
                        to_cnt      <= '0;
                    end else if (iomem_ready) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= 4'h0;
                        rdata_q     <= iomem_rdata;
                        tx_valid    <= 1'b1;
                        tx_data     <= ST_OK;
                        resp_idx    <= 3'd0;
                        resp_last   <= is_write ? 3'd0 : 3'd4;
                        state       <= S_RESP;
                    end else if (to_cnt == TO_LAST) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= 4'h0;
                        tx_valid    <= 1'b1;
                        tx_data     <= ST_TIMEOUT;
                        resp_idx    <= 3'd0;
                        resp_last   <= 3'd0;
                        state       <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        if (resp_idx == resp_last) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            resp_idx <= resp_idx + 3'd1;
                            tx_data  <= rdata_byte(rdata_q, resp_idx + 3'd1);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    rx_ready <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_host_bridge.sv
// Randomized bench for iomem_host_bridge: frame sender, iomem responder model,
// tx sink, and a frame-level reference model of the expected bus and byte traffic.
module tb_iomem_host_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    iomem_host_bridge #(.TIMEOUT_CYCLES(T), .TO_BITS(16)) dut (
        .clk(clk), .resetn(resetn),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] txn_addr_q[$], txn_wdata_q[$], exp_addr_q[$], exp_wdata_q[$];
    logic [3:0]  txn_wstrb_q[$], exp_wstrb_q[$];
    int          txn_len_q[$], exp_len_q[$];
    int          plan_d_q[$];
    logic [31:0] plan_r_q[$];

    int hold_err = 0, par_err = 0, stab_err = 0, wstrb_err = 0, b2b_err = 0;
    int tx_stall = 0;
    bit spurious = 1'b0;

    // iomem responder + bus monitor; delay d = ready on the d-th valid cycle, 0 = never
    bit          in_txn = 1'b0, ready_hit = 1'b0;
    int          vcyc = 0, cur_delay = 1;
    logic [31:0] cur_rdata, a0, w0;
    logic [3:0]  s0;
    initial begin
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (iomem_valid && ready_hit) b2b_err++;
            ready_hit = 1'b0;
            if (!iomem_valid && iomem_wstrb != 4'h0) wstrb_err++;
            if (iomem_valid) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    vcyc = 0;
                    if (plan_d_q.size() > 0) begin
                        cur_delay = plan_d_q.pop_front();
                        cur_rdata = plan_r_q.pop_front();
                    end else begin
                        cur_delay = 1;
                        cur_rdata = 32'h0;
                    end
                    a0 = iomem_addr; w0 = iomem_wdata; s0 = iomem_wstrb;
                    txn_addr_q.push_back(a0);
                    txn_wdata_q.push_back(w0);
                    txn_wstrb_q.push_back(s0);
                end else if (iomem_addr !== a0 || iomem_wdata !== w0 || iomem_wstrb !== s0) begin
                    stab_err++;
                end
                vcyc++;
                if (vcyc == cur_delay) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = cur_rdata;
                    ready_hit = 1'b1;
                end else begin
                    iomem_ready = 1'b0;
                    iomem_rdata = $urandom;
                end
            end else begin
                if (in_txn) begin
                    txn_len_q.push_back(vcyc);
                    in_txn = 1'b0;
                end
                iomem_ready = spurious && ($urandom_range(0, 3) == 0);
                iomem_rdata = $urandom;
            end
        end
    end

    // tx sink: stalls tx_stall cycles per byte (negative = random 0..3), checks hold stability
    bit         holding = 1'b0;
    logic [7:0] held;
    int         wcnt = 0, lim = 0;
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (tx_valid && rx_ready) par_err++;
            if (iomem_valid && (rx_ready || tx_valid)) par_err++;
            if (tx_valid) begin
                if (holding && tx_data !== held) hold_err++;
                if (!holding) begin
                    held = tx_data;
                    holding = 1'b1;
                    wcnt = 0;
                    lim = (tx_stall < 0) ? int'($urandom_range(0, 3)) : tx_stall;
                end
                if (wcnt >= lim) begin
                    tx_ready = 1'b1;
                    tx_q.push_back(tx_data);
                    holding = 1'b0;
                end else begin
                    tx_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                if (holding) hold_err++;
                holding = 1'b0;
                tx_ready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] pack_q(input logic [7:0] q[$]);
        logic [39:0] v = '0;
        foreach (q[i]) v = {v[31:0], q[i]};
        return v;
    endfunction

    // Reference model: what one frame should produce on the bus and the tx stream.
    function automatic void expect_frame(input logic [7:0] op, input logic [31:0] a, wd, rd, input int dly);
        bit ok;
        if (op != 8'h52 && op != 8'h57) begin
            exp_q.push_back(8'h3F);
            return;
        end
        plan_d_q.push_back(dly);
        plan_r_q.push_back(rd);
        ok = (dly >= 1 && dly <= T);
        exp_addr_q.push_back(a);
        exp_wdata_q.push_back(wd);
        exp_wstrb_q.push_back(op == 8'h57 ? 4'hF : 4'h0);
        exp_len_q.push_back(ok ? dly : T);
        if (!ok) exp_q.push_back(8'hEE);
        else begin
            exp_q.push_back(8'h00);
            if (op == 8'h52) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
        end
    endfunction

    task automatic clear_logs();
        tx_q.delete(); exp_q.delete();
        txn_addr_q.delete(); txn_wdata_q.delete(); txn_wstrb_q.delete(); txn_len_q.delete();
        exp_addr_q.delete(); exp_wdata_q.delete(); exp_wstrb_q.delete(); exp_len_q.delete();
        plan_d_q.delete(); plan_r_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!rx_ready) begin
            n_chk++;
            $display("FAIL rx_accept_timeout: rx_ready=0 after %0d cycles, required 1", n);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data = $urandom;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, wd, input bit gaps);
        send_byte(op);
        if (op == 8'h52 || op == 8'h57)
            for (int i = 3; i >= 0; i--) begin
                send_byte(a[8*i +: 8]);
                if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        if (op == 8'h57)
            for (int i = 3; i >= 0; i--) begin
                send_byte(wd[8*i +: 8]);
                if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
    endtask

    task automatic wait_idle(input int nb);
        int n = 0;
        while ((tx_q.size() < nb || busy) && n < 4000) begin @(posedge clk); #1; n++; end
        if (n >= 4000) begin
            n_chk++;
            $display("FAIL wait_idle: tx bytes=%0d busy=%0b, required %0d bytes and idle", tx_q.size(), busy, nb);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({rx_ready, tx_valid, iomem_valid, busy, iomem_wstrb, iomem_addr, iomem_wdata, tx_data} !== '0)
            $display("FAIL reset_outputs: rx_ready=%b tx_valid=%b iomem_valid=%b busy=%b wstrb=%h addr=%h wdata=%h tx_data=%h, required all 0",
                     rx_ready, tx_valid, iomem_valid, busy, iomem_wstrb, iomem_addr, iomem_wdata, tx_data);
        else n_pass++;
        resetn = 1'b1;
        #1;
        n_chk++;
        if (rx_ready !== 1'b0) $display("FAIL rx_ready_before_edge: got %b, required 0", rx_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (rx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rx_ready_after_edge: rx_ready=%b busy=%b, required 1 0", rx_ready, busy);
        else n_pass++;
    endtask

    task automatic test_read();
        clear_logs();
        tx_stall = 0;
        expect_frame(8'h52, 32'h03000004, 32'h0, 32'h12345678, 3);
        send_frame(8'h52, 32'h03000004, 32'h0, 1'b0);
        wait_idle(5);
        n_chk++;
        if (tx_q.size() != 5 || pack_q(tx_q) !== 40'h0012345678)
            $display("FAIL read_bytes: got %0d bytes %h, required 5 bytes 0012345678", tx_q.size(), pack_q(tx_q));
        else n_pass++;
        n_chk++;
        if (txn_addr_q.size() != 1 || txn_addr_q[0] !== 32'h03000004 || txn_wstrb_q[0] !== 4'h0)
            $display("FAIL read_bus: txns=%0d addr=%h wstrb=%h, required 1 03000004 0",
                     txn_addr_q.size(), txn_addr_q[0], txn_wstrb_q[0]);
        else n_pass++;
        n_chk++;
        if (txn_len_q.size() != 1 || txn_len_q[0] != 3)
            $display("FAIL read_valid_len: got %0d, required 3", txn_len_q[0]);
        else n_pass++;
    endtask

    task automatic test_write();
        clear_logs();
        expect_frame(8'h57, 32'h03000000, 32'h0000000A, 32'h0, 1);
        send_frame(8'h57, 32'h03000000, 32'h0000000A, 1'b0);
        wait_idle(1);
        n_chk++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h00)
            $display("FAIL write_bytes: got %0d bytes %h, required 1 byte 00", tx_q.size(), pack_q(tx_q));
        else n_pass++;
        n_chk++;
        if (txn_addr_q.size() != 1 || txn_addr_q[0] !== 32'h03000000 || txn_wdata_q[0] !== 32'h0000000A
            || txn_wstrb_q[0] !== 4'hF || txn_len_q[0] != 1)
            $display("FAIL write_bus: txns=%0d addr=%h wdata=%h wstrb=%h len=%0d, required 1 03000000 0000000a f 1",
                     txn_addr_q.size(), txn_addr_q[0], txn_wdata_q[0], txn_wstrb_q[0], txn_len_q[0]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int dl[3] = '{0, T, 2};
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a = $urandom, rd = $urandom;
            clear_logs();
            expect_frame(8'h52, a, 32'h0, rd, dl[k]);
            send_frame(8'h52, a, 32'h0, 1'b0);
            wait_idle(exp_q.size());
            n_chk++;
            if (tx_q.size() != exp_q.size() || pack_q(tx_q) !== pack_q(exp_q))
                $display("FAIL timeout_bytes[%0d]: got %0d bytes %h, required %0d bytes %h",
                         k, tx_q.size(), pack_q(tx_q), exp_q.size(), pack_q(exp_q));
            else n_pass++;
            n_chk++;
            if (txn_len_q.size() != 1 || txn_len_q[0] != exp_len_q[0] || txn_addr_q[0] !== a)
                $display("FAIL timeout_bus[%0d]: len=%0d addr=%h, required %0d %h", k, txn_len_q[0], txn_addr_q[0], exp_len_q[0], a);
            else n_pass++;
        end
    endtask

    task automatic test_bad_opcode();
        logic [31:0] a = $urandom, rd = $urandom;
        clear_logs();
        expect_frame(8'hA5, 32'h0, 32'h0, 32'h0, 1);
        send_frame(8'hA5, 32'h0, 32'h0, 1'b0);
        wait_idle(1);
        n_chk++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h3F || txn_addr_q.size() != 0)
            $display("FAIL badop: bytes=%0d byte0=%h txns=%0d, required 1 3f 0", tx_q.size(), tx_q[0], txn_addr_q.size());
        else n_pass++;
        clear_logs();
        expect_frame(8'h52, a, 32'h0, rd, 1);
        send_frame(8'h52, a, 32'h0, 1'b0);
        wait_idle(5);
        n_chk++;
        if (tx_q.size() != 5 || pack_q(tx_q) !== pack_q(exp_q))
            $display("FAIL badop_then_read: got %h, required %h", pack_q(tx_q), pack_q(exp_q));
        else n_pass++;
    endtask

    task automatic test_tx_backpressure();
        logic [31:0] a = $urandom, rd = $urandom;
        int he = hold_err, pe = par_err;
        clear_logs();
        tx_stall = 10;
        expect_frame(8'h52, a, 32'h0, rd, 2);
        send_frame(8'h52, a, 32'h0, 1'b0);
        wait_idle(5);
        tx_stall = 0;
        n_chk++;
        if (tx_q.size() != 5 || pack_q(tx_q) !== pack_q(exp_q))
            $display("FAIL backpressure_bytes: got %h, required %h", pack_q(tx_q), pack_q(exp_q));
        else n_pass++;
        n_chk++;
        if (hold_err != he || par_err != pe || rx_ready !== 1'b1)
            $display("FAIL backpressure_hold: hold_err=+%0d rx_ready_overlap=+%0d rx_ready=%b, required 0 0 1",
                     hold_err - he, par_err - pe, rx_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] a = $urandom, rd = $urandom;
        int n = 0;
        clear_logs();
        send_byte(8'h52); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL midframe_busy: got %b, required 1", busy); else n_pass++;
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({rx_ready, busy, tx_valid, iomem_valid, iomem_addr} !== '0)
            $display("FAIL reset_addr_phase: rx_ready=%b busy=%b tx_valid=%b iomem_valid=%b addr=%h, required all 0",
                     rx_ready, busy, tx_valid, iomem_valid, iomem_addr);
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        expect_frame(8'h52, 32'h03000004, 32'h0, 32'hCAFEF00D, 2);
        send_frame(8'h52, 32'h03000004, 32'h0, 1'b0);
        wait_idle(5);
        n_chk++;
        if (pack_q(tx_q) !== 40'h00CAFEF00D || txn_addr_q.size() != 1 || txn_addr_q[0] !== 32'h03000004)
            $display("FAIL read_after_reset1: bytes=%h txns=%0d, required 00cafef00d 1", pack_q(tx_q), txn_addr_q.size());
        else n_pass++;

        clear_logs();
        expect_frame(8'h52, a, 32'h0, rd, 0);
        send_frame(8'h52, a, 32'h0, 1'b0);
        while (!iomem_valid && n < 50) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (iomem_valid !== 1'b1) $display("FAIL bus_before_reset: iomem_valid=%b, required 1", iomem_valid); else n_pass++;
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({iomem_valid, iomem_wstrb, rx_ready, tx_valid, busy} !== '0)
            $display("FAIL reset_bus_phase: iomem_valid=%b wstrb=%h rx_ready=%b tx_valid=%b busy=%b, required all 0",
                     iomem_valid, iomem_wstrb, rx_ready, tx_valid, busy);
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        expect_frame(8'h52, a, 32'h0, rd, 1);
        send_frame(8'h52, a, 32'h0, 1'b0);
        wait_idle(5);
        n_chk++;
        if (tx_q.size() != 5 || pack_q(tx_q) !== pack_q(exp_q))
            $display("FAIL read_after_reset2: got %h, required %h", pack_q(tx_q), pack_q(exp_q));
        else n_pass++;
    endtask

    task automatic test_random();
        int bad_tx = 0, bad_bus = 0;
        clear_logs();
        spurious = 1'b1;
        tx_stall = -1;
        for (int f = 0; f < 40; f++) begin
            int r = $urandom_range(0, 9);
            logic [7:0]  op = (r < 5) ? 8'h52 : 8'h57;
            logic [31:0] a = $urandom, wd = $urandom, rd = $urandom;
            if (r == 0) begin
                op = $urandom;
                while (op == 8'h52 || op == 8'h57) op = $urandom;
            end
            expect_frame(op, a, wd, rd, $urandom_range(0, 20));
            send_frame(op, a, wd, 1'b1);
        end
        wait_idle(exp_q.size());
        spurious = 1'b0;
        tx_stall = 0;
        n_chk++;
        if (tx_q.size() != exp_q.size()) $display("FAIL rand_tx_count: got %0d, required %0d", tx_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) if (tx_q[i] !== exp_q[i]) bad_tx++;
        n_chk++;
        if (bad_tx != 0) $display("FAIL rand_tx_stream: %0d bytes differ, required 0", bad_tx); else n_pass++;
        n_chk++;
        if (txn_len_q.size() != exp_len_q.size())
            $display("FAIL rand_txn_count: got %0d, required %0d", txn_len_q.size(), exp_len_q.size());
        else n_pass++;
        for (int i = 0; i < exp_len_q.size() && i < txn_len_q.size(); i++) begin
            if (txn_addr_q[i] !== exp_addr_q[i] || txn_wstrb_q[i] !== exp_wstrb_q[i] || txn_len_q[i] != exp_len_q[i])
                bad_bus++;
            else if (exp_wstrb_q[i] == 4'hF && txn_wdata_q[i] !== exp_wdata_q[i])
                bad_bus++;
        end
        n_chk++;
        if (bad_bus != 0) $display("FAIL rand_bus: %0d transactions differ, required 0", bad_bus); else n_pass++;
        n_chk++;
        if (hold_err + par_err + stab_err + wstrb_err + b2b_err != 0)
            $display("FAIL protocol: hold=%0d overlap=%0d stable=%0d wstrb=%0d back2back=%0d, required all 0",
                     hold_err, par_err, stab_err, wstrb_err, b2b_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_bad_opcode();
        test_tx_backpressure();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
